reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 39 +++
 rtl/reg_file.sv | 53 +++++
 tb/tb_reg_file.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared CPU definitions: register-file geometry and timing constants used by reg_file, alu and cpu.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// DATA_WIDTH / ADDR_WIDTH size the datapath; REG_COUNT follows from ADDR_WIDTH.
// READ_DELAY / WRITE_DELAY record the settling figures of the behavioural CPU model.
// Synthesized logic ignores them: reads are purely combinational and writes land
// on the clock edge.
package reg_file_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int ADDR_WIDTH  = 3;
   localparam int REG_COUNT   = 2 ** ADDR_WIDTH;
   localparam int READ_DELAY  = 2;
   localparam int WRITE_DELAY = 1;

   // Value every register takes on reset.
   localparam logic [DATA_WIDTH-1:0] REG_RESET_VAL = '0;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   // One write request as sampled on a clock edge.
   typedef struct packed {
      logic  en;
      addr_t addr;
      data_t dat;
   } wr_req_t;

   // Bundles the raw write-port signals into a request.
   function automatic wr_req_t make_wr_req(input logic en, input addr_t addr, input data_t dat);
      wr_req_t r;
      r.en   = en;
      r.addr = addr;
      r.dat  = dat;
      return r;
   endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH x DATA_WIDTH register file, one write port, two independent read ports.
// Latency: reads are combinational; a write or reset takes effect on the rising CLK edge.
// Backpressure: none, every edge accepts a write.
//
// Ports:
//   CLK          rising-edge clock, all state changes here
//   RESET        synchronous active-high clear of every register (beats WRITE)
//   IN           write data (ALU RESULT or immediate)
//   INADDRESS    write register index
//   WRITE        write enable, sampled only at the rising edge
//   OUT1ADDRESS  read port 1 index  -> OUT1 (ALU DATA1)
//   OUT2ADDRESS  read port 2 index  -> OUT2 (ALU DATA2 path)
module reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH  = reg_file_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH  = reg_file_pkg::ADDR_WIDTH,
   parameter int READ_DELAY  = reg_file_pkg::READ_DELAY,
   parameter int WRITE_DELAY = reg_file_pkg::WRITE_DELAY
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   output logic [DATA_WIDTH-1:0] OUT1,
   output logic [DATA_WIDTH-1:0] OUT2
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   // Single storage array; every index of an ADDR_WIDTH-bit address exists,
   // so a known address can never read out of range.
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (WRITE) begin
         regs[INADDRESS] <= IN;
      end
   end

   // No write-to-read bypass: a read of the register being written shows the
   // old contents until the edge commits the new value.
   assign OUT1 = regs[OUT1ADDRESS];
   assign OUT2 = regs[OUT2ADDRESS];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file against an array reference model.
// Latency: expected read data queued at stimulus time, compared in the same low clock phase.
// Backpressure: n/a.
module tb_reg_file;
   import reg_file_pkg::*;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       WRITE = 1'b0;
   logic [7:0] IN = 8'h00;
   logic [2:0] INADDRESS = 3'd0;
   logic [2:0] OUT1ADDRESS = 3'd0;
   logic [2:0] OUT2ADDRESS = 3'd0;
   logic [7:0] OUT1, OUT2;

   always #5 CLK = ~CLK;

   reg_file dut (
      .CLK(CLK),
      .RESET(RESET),
      .IN(IN),
      .INADDRESS(INADDRESS),
      .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS),
      .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(OUT1),
      .OUT2(OUT2)
   );

   // Reference model: what each register holds right now.
   logic [7:0] model [8];

   logic [7:0] q1 [$];
   logic [7:0] q2 [$];
   string      qtag [$];

   int tests = 0;
   int fails = 0;

   // One clock period: drive inputs at negedge, queue what the read ports must
   // show before the coming edge, then advance the model by that edge's effect.
   task automatic cycle(input bit rst, input bit wr, input logic [7:0] d, input logic [2:0] wa,
                        input logic [2:0] ra1, input logic [2:0] ra2, input bit chk, input string tag);
      @(negedge CLK);
      RESET = rst;
      WRITE = wr;
      IN = d;
      INADDRESS = wa;
      OUT1ADDRESS = ra1;
      OUT2ADDRESS = ra2;
      if (chk) begin
         q1.push_back(model[ra1]);
         q2.push_back(model[ra2]);
         qtag.push_back(tag);
      end
      if (rst) begin
         for (int i = 0; i < 8; i++) model[i] = 8'h00;
      end else if (wr) begin
         model[wa] = d;
      end
   endtask

   // Monitor: read ports are valid 2 time units into the low phase.
   initial begin
      logic [7:0] e1, e2;
      string t;
      forever begin
         @(negedge CLK);
         #2;
         if (qtag.size() > 0) begin
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            t  = qtag.pop_front();
            tests++;
            if (OUT1 !== e1) begin
               fails++;
               $display("FAIL %s OUT1 (addr %0d) got %h expected %h", t, OUT1ADDRESS, OUT1, e1);
            end
            tests++;
            if (OUT2 !== e2) begin
               fails++;
               $display("FAIL %s OUT2 (addr %0d) got %h expected %h", t, OUT2ADDRESS, OUT2, e2);
            end
         end
      end
   end

   initial begin
      logic [7:0] alu_res;

      for (int i = 0; i < 8; i++) model[i] = 8'hxx;

      // Reset pulse, then sweep both ports over every address.
      cycle(1, 0, 8'h00, 3'd0, 3'd0, 3'd0, 0, "rst");
      for (int a = 0; a < 8; a++) cycle(0, 0, 8'h00, 3'd0, 3'(a), 3'(7 - a), 1, "rst_read");

      // Write/readback on consecutive edges.
      cycle(0, 1, 8'h5A, 3'd3, 3'd0, 3'd1, 1, "wr_r3");
      cycle(0, 1, 8'hC3, 3'd7, 3'd0, 3'd1, 1, "wr_r7");
      cycle(0, 0, 8'h00, 3'd0, 3'd3, 3'd7, 1, "readback");

      // Gated write: WRITE low with activity on IN/INADDRESS.
      repeat (3) cycle(0, 0, 8'hFF, 3'd3, 3'd3, 3'd3, 1, "gated");
      cycle(0, 0, 8'h00, 3'd0, 3'd3, 3'd3, 1, "gated_after");

      // Read-during-write: old value before the edge, new value after.
      cycle(0, 1, 8'h11, 3'd2, 3'd2, 3'd2, 1, "rdw_setup");
      cycle(0, 1, 8'h22, 3'd2, 3'd2, 3'd2, 1, "rdw_old");
      cycle(0, 0, 8'h00, 3'd0, 3'd2, 3'd2, 1, "rdw_new");

      // Back-to-back writes to one register, last one persists.
      cycle(0, 1, 8'hAA, 3'd6, 3'd6, 3'd0, 1, "b2b_first");
      cycle(0, 1, 8'hBB, 3'd6, 3'd6, 3'd0, 1, "b2b_second");
      cycle(0, 0, 8'h00, 3'd0, 3'd6, 3'd6, 1, "b2b_last");

      // Reset beats a coinciding write; write allowed right after reset drops.
      cycle(1, 1, 8'h77, 3'd1, 3'd1, 3'd7, 1, "rst_pri");
      cycle(0, 1, 8'h77, 3'd1, 3'd1, 3'd7, 1, "rst_pri_cleared");
      cycle(0, 0, 8'h00, 3'd0, 3'd1, 3'd0, 1, "post_rst_write");

      // Reset and write glitches between edges must not change anything.
      cycle(0, 0, 8'h00, 3'd0, 3'd1, 3'd5, 1, "glitch_pre");
      #3;
      RESET = 1'b1;
      WRITE = 1'b1;
      IN = 8'hFF;
      INADDRESS = 3'd5;
      #1;
      RESET = 1'b0;
      WRITE = 1'b0;
      cycle(0, 0, 8'h00, 3'd0, 3'd1, 3'd5, 1, "glitch_post");

      // ALU hookup: add r1 + r2 and write the result back to r4.
      cycle(0, 1, 8'h05, 3'd1, 3'd0, 3'd0, 1, "alu_r1");
      cycle(0, 1, 8'h03, 3'd2, 3'd0, 3'd0, 1, "alu_r2");
      alu_res = model[1] + model[2];
      cycle(0, 1, alu_res, 3'd4, 3'd1, 3'd2, 1, "alu_ops");
      cycle(0, 0, 8'h00, 3'd0, 3'd4, 3'd4, 1, "alu_wb");

      // Randomized traffic with occasional resets.
      repeat (400) begin
         cycle(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
               3'($urandom), 3'($urandom), 3'($urandom), 1, "random");
      end

      // Drain the scoreboard.
      repeat (3) @(negedge CLK);
      #3;
      tests++;
      if (qtag.size() != 0) begin
         fails++;
         $display("FAIL drain scoreboard entries left %0d expected 0", qtag.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
